// File: rtl/fgen_wave_player.sv
// Sample-memory waveform player: decodes 32-bit command words into RAM writes and
// run/stop control, then streams samples into the DAC FIFO. Optional macro FGEN_READBACK_EN adds RAM readback.
module fgen_wave_player #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 10,
    parameter int REP_W  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    input  logic [31:0]       cmd_word,
    input  logic              fifo_almost_full,
    output logic [DATA_W-1:0] fifo_din,
    output logic              fifo_wr_en,
    output logic              dac_enable,
    output logic              busy,
    output logic              done,
    output logic              cmd_err,
    output logic [1:0]        state_out
`ifdef FGEN_READBACK_EN
    ,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data
`endif
);

    // Handshakes: cmd_valid is a one-cycle strobe with no ready (commands are never
    // stalled, only accepted or rejected via cmd_err); fifo_wr_en writes one sample per
    // cycle and no new read is issued while fifo_almost_full is high.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [3:0] OP_WRITE = 4'd1;
    localparam logic [3:0] OP_RUN   = 4'd2;
    localparam logic [3:0] OP_STOP  = 4'd3;
`ifdef FGEN_READBACK_EN
    localparam logic [3:0] OP_READ  = 4'd5;
`endif

    state_t              state, state_d;
    logic [ADDR_W-1:0]   rd_addr;
    logic [ADDR_W-1:0]   last_addr;
    logic [REP_W-1:0]    rep_cnt;
    logic                stop_pend;
    logic [DATA_W-1:0]   mem [0:(1<<ADDR_W)-1];

    logic [3:0]          op;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [DATA_W-1:0]   cmd_data;
    logic [ADDR_W-1:0]   cmd_last;
    logic [REP_W-1:0]    cmd_reps;
    logic                is_stop;

    logic rd_issue, wrap, finish, stop_run, mem_we, load_run, err_d;
`ifdef FGEN_READBACK_EN
    logic rb_req;
`endif

    assign op       = cmd_word[31:28];
    assign cmd_addr = cmd_word[DATA_W+ADDR_W-1:DATA_W];
    assign cmd_data = cmd_word[DATA_W-1:0];
    assign cmd_last = cmd_word[ADDR_W-1:0];
    assign cmd_reps = cmd_word[16+REP_W-1:16];
    assign is_stop  = cmd_valid && (op == OP_STOP);

    assign busy      = (state != ST_IDLE);
    assign state_out = state;

    always_comb begin
        state_d  = state;
        rd_issue = 1'b0;
        wrap     = 1'b0;
        finish   = 1'b0;
        stop_run = 1'b0;
        mem_we   = 1'b0;
        load_run = 1'b0;
        err_d    = 1'b0;
`ifdef FGEN_READBACK_EN
        rb_req   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (op)
                        OP_WRITE: mem_we = 1'b1;
                        OP_RUN: begin
                            load_run = 1'b1;
                            state_d  = ST_RUN;
                        end
                        OP_STOP:  err_d = 1'b0;
`ifdef FGEN_READBACK_EN
                        OP_READ:  rb_req = 1'b1;
`endif
                        default:  err_d = 1'b1;
                    endcase
                end
            end
            ST_RUN: begin
                err_d = cmd_valid && !is_stop;
                // STOP wins over a read issue in the same cycle.
                if (is_stop) begin
                    stop_run = 1'b1;
                    state_d  = ST_DRAIN;
                end else if (!fifo_almost_full) begin
                    rd_issue = 1'b1;
                    if (rd_addr == last_addr) begin
                        wrap = 1'b1;
                        if (rep_cnt == REP_W'(1)) begin
                            finish  = 1'b1;
                            state_d = ST_DRAIN;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                err_d   = cmd_valid && !is_stop;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[cmd_addr] <= cmd_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            rd_addr    <= '0;
            last_addr  <= '0;
            rep_cnt    <= '0;
            stop_pend  <= 1'b0;
            fifo_din   <= '0;
            fifo_wr_en <= 1'b0;
            dac_enable <= 1'b0;
            done       <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            state      <= state_d;
            fifo_wr_en <= rd_issue;
            done       <= finish;
            cmd_err    <= err_d;
            stop_pend  <= stop_run;
            if (rd_issue) fifo_din <= mem[rd_addr];
            // rep_cnt of zero means continuous playback and is never decremented.
            if (load_run) begin
                rd_addr   <= '0;
                last_addr <= cmd_last;
                rep_cnt   <= cmd_reps;
            end else if (rd_issue) begin
                rd_addr <= wrap ? '0 : rd_addr + ADDR_W'(1);
                if (wrap && rep_cnt != '0) rep_cnt <= rep_cnt - REP_W'(1);
            end
            // After a natural finish the DAC stays enabled so it can empty the FIFO.
            if (load_run)
                dac_enable <= 1'b1;
            else if (state == ST_IDLE && is_stop)
                dac_enable <= 1'b0;
            else if (state == ST_DRAIN && (stop_pend || is_stop))
                dac_enable <= 1'b0;
        end
    end

`ifdef FGEN_READBACK_EN
    logic              rb_pend;
    logic [ADDR_W-1:0] rb_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb_pend   <= 1'b0;
            rb_addr   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rb_pend   <= rb_req;
            if (rb_req) rb_addr <= cmd_addr;
            rsp_valid <= rb_pend;
            if (rb_pend) rsp_data <= {4'h5, 28'({rb_addr, mem[rb_addr]})};
        end
    end
`endif

endmodule

// File: tb/tb_fgen_wave_player.sv
// Bench for fgen_wave_player: directed test-plan scenarios plus randomized commands,
// checked each cycle against a sample-count model of the player.
module tb_fgen_wave_player;
    localparam int DATA_W = 14;
    localparam int ADDR_W = 10;
    localparam int REP_W  = 12;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic [31:0]       cmd_word = '0;
    logic              fifo_almost_full = 1'b0;
    logic [DATA_W-1:0] fifo_din;
    logic              fifo_wr_en, dac_enable, busy, done, cmd_err;
    logic [1:0]        state_out;
`ifdef FGEN_READBACK_EN
    logic              rsp_valid;
    logic [31:0]       rsp_data;
`endif

    fgen_wave_player #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REP_W(REP_W)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_word(cmd_word),
        .fifo_almost_full(fifo_almost_full), .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en),
        .dac_enable(dac_enable), .busy(busy), .done(done), .cmd_err(cmd_err),
        .state_out(state_out)
`ifdef FGEN_READBACK_EN
        , .rsp_valid(rsp_valid), .rsp_data(rsp_data)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The run is modelled as a count of issued samples: sample k comes from address
    // k mod length, and a finite run ends after length*reps samples.
    int                m_phase = 0;
    int                m_len = 1;
    int                m_total = 0;
    int                m_count = 0;
    bit                m_stopped = 1'b0;
    logic [DATA_W-1:0] m_mem [DEPTH];
    bit                e_wr = 1'b0, e_done = 1'b0, e_err = 1'b0, e_dac = 1'b0;
    logic [DATA_W-1:0] e_din = '0;
`ifdef FGEN_READBACK_EN
    bit                m_rb_pend = 1'b0;
    logic [ADDR_W-1:0] m_rb_addr = '0;
    bit                e_rsp_valid = 1'b0;
    logic [31:0]       e_rsp_data = '0;
`endif

    task automatic model_step();
        logic [3:0] op;
        bit v, stp;
        int nxt;
        v   = cmd_valid;
        op  = cmd_word[31:28];
        stp = v && (op == 4'd3);
        nxt = m_phase;
        e_wr = 1'b0; e_done = 1'b0; e_err = 1'b0;
`ifdef FGEN_READBACK_EN
        e_rsp_valid = m_rb_pend;
        if (m_rb_pend) e_rsp_data = {4'h5, 28'({m_rb_addr, m_mem[m_rb_addr]})};
        m_rb_pend = 1'b0;
`endif
        case (m_phase)
            0: if (v) begin
                case (op)
                    4'd1: m_mem[cmd_word[23:14]] = cmd_word[13:0];
                    4'd2: begin
                        m_len   = int'(cmd_word[9:0]) + 1;
                        m_total = m_len * int'(cmd_word[27:16]);
                        m_count = 0;
                        nxt     = 1;
                        e_dac   = 1'b1;
                    end
                    4'd3: e_dac = 1'b0;
`ifdef FGEN_READBACK_EN
                    4'd5: begin
                        m_rb_pend = 1'b1;
                        m_rb_addr = cmd_word[23:14];
                    end
`endif
                    default: e_err = 1'b1;
                endcase
            end
            1: begin
                if (v && !stp) e_err = 1'b1;
                if (stp) begin
                    nxt = 2;
                    m_stopped = 1'b1;
                end else if (!fifo_almost_full) begin
                    e_wr  = 1'b1;
                    e_din = m_mem[m_count % m_len];
                    m_count++;
                    if (m_total != 0 && m_count == m_total) begin
                        nxt    = 2;
                        e_done = 1'b1;
                    end
                end
            end
            default: begin
                if (v && !stp) e_err = 1'b1;
                if (m_stopped || stp) e_dac = 1'b0;
                m_stopped = 1'b0;
                nxt = 0;
            end
        endcase
        m_phase = nxt;
    endtask

    always @(posedge clk) if (rst_n) model_step();

    always @(negedge rst_n) begin
        m_phase = 0; m_stopped = 1'b0;
        e_wr = 1'b0; e_done = 1'b0; e_err = 1'b0; e_dac = 1'b0;
`ifdef FGEN_READBACK_EN
        m_rb_pend = 1'b0; e_rsp_valid = 1'b0; e_rsp_data = '0;
`endif
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("fifo_wr_en", fifo_wr_en, e_wr);
        if (e_wr) chk("fifo_din", fifo_din, e_din);
        chk("done", done, e_done);
        chk("cmd_err", cmd_err, e_err);
        chk("dac_enable", dac_enable, e_dac);
        chk("state_out", state_out, m_phase[1:0]);
        chk("busy", busy, m_phase != 0);
`ifdef FGEN_READBACK_EN
        chk("rsp_valid", rsp_valid, e_rsp_valid);
        if (e_rsp_valid) chk("rsp_data", rsp_data, e_rsp_data);
`endif
    end

    // ---------------- observation for directed literal checks ----------------
    int                cyc = 0;
    logic [DATA_W-1:0] got_q[$];
    logic [DATA_W-1:0] exp_q[$];
    int done_cnt = 0, err_cnt = 0, first_wr = -1, last_wr = -1, done_cyc = -1;
`ifdef FGEN_READBACK_EN
    logic [31:0]       rsp_q[$];
`endif

    always @(negedge clk) begin
        cyc++;
        if (fifo_wr_en) begin
            got_q.push_back(fifo_din);
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (cmd_err) err_cnt++;
`ifdef FGEN_READBACK_EN
        if (rsp_valid) rsp_q.push_back(rsp_data);
`endif
    end

    task automatic clear_obs();
        got_q.delete();
        done_cnt = 0; err_cnt = 0; first_wr = -1; last_wr = -1; done_cyc = -1;
    endtask

    task automatic check_seq(input string name);
        chk({name, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk(name, got_q[i], exp_q[i]);
    endtask

    task automatic load_exp4();
        exp_q.delete();
        for (int r = 0; r < 4; r++) exp_q.push_back(14'((r + 1) * 100));
    endtask

    // ---------------- driver tasks ----------------
    function automatic logic [31:0] wr_word(input int a, input int d);
        return {4'h1, 4'h0, 10'(a), 14'(d)};
    endfunction

    function automatic logic [31:0] run_word(input int last, input int reps);
        return {4'h2, 12'(reps), 6'h0, 10'(last)};
    endfunction

    localparam logic [31:0] STOP_WORD = 32'h3000_0000;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        @(negedge clk); #1;
        cmd_valid = 1'b1;
        cmd_word  = w;
        @(negedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (state_out != 2'd0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (state_out != 2'd0) chk("idle_timeout", state_out, 0);
        #1;
    endtask

    function automatic logic [31:0] rand_cmd();
        int r;
        logic [3:0] op;
        r = $urandom_range(0, 99);
        if (r < 25) return wr_word($urandom_range(0, DEPTH - 1), $urandom_range(0, 16383));
        if (r < 50) return run_word(($urandom_range(0, 9) == 0) ? $urandom_range(0, DEPTH - 1)
                                                                : $urandom_range(0, 15),
                                    $urandom_range(0, 3));
        if (r < 80) return {4'h3, 28'($urandom)};
        if (r < 92) begin
            op = 4'($urandom_range(0, 15));
            while (op == 4'd1 || op == 4'd2 || op == 4'd3 || op == 4'd5)
                op = 4'($urandom_range(0, 15));
            return {op, 28'($urandom)};
        end
        return {4'h5, 4'h0, 10'($urandom_range(0, DEPTH - 1)), 14'h0};
    endfunction

    logic [DATA_W-1:0] fill [DEPTH];

    // ---------------- main sequence ----------------
    initial begin
        tick(3);
        chk("rst_fifo_wr_en", fifo_wr_en, 0);
        chk("rst_fifo_din", fifo_din, 0);
        chk("rst_dac_enable", dac_enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cmd_err", cmd_err, 0);
        chk("rst_state_out", state_out, 0);
        rst_n = 1'b1;
        tick(2);

        // Full-depth single pass.
        for (int i = 0; i < DEPTH; i++) begin
            fill[i] = 14'($urandom_range(0, 16383));
            send(wr_word(i, int'(fill[i])));
        end
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(fill[i]);
        clear_obs();
        send(run_word(DEPTH - 1, 1));
        wait_idle(DEPTH + 50);
        check_seq("full_depth");
        chk("full_depth_done", done_cnt, 1);

        // Four samples, two repeats, no backpressure.
        for (int i = 0; i < 4; i++) send(wr_word(i, (i + 1) * 100));
        clear_obs();
        send(run_word(3, 2));
        wait_idle(50);
        load_exp4();
        for (int i = 0; i < 4; i++) exp_q.push_back(exp_q[i]);
        check_seq("rep2");
        chk("rep2_done_cnt", done_cnt, 1);
        chk("rep2_done_on_last", done_cyc, last_wr);
        chk("rep2_consecutive", last_wr - first_wr, 7);
        tick(1);
        chk("rep2_dac_held", dac_enable, 1);

        // Same program with almost-full asserted mid-run.
        clear_obs();
        send(run_word(3, 2));
        tick(1);
        fifo_almost_full = 1'b1;
        tick(4);
        fifo_almost_full = 1'b0;
        wait_idle(50);
        check_seq("af_rep2");
        chk("af_done_cnt", done_cnt, 1);

        // Continuous single-sample loop, stopped.
        clear_obs();
        send(run_word(0, 0));
        tick(20);
        send(STOP_WORD);
        wait_idle(10);
        chk("cont_no_done", done_cnt, 0);
        chk("cont_dac_off", dac_enable, 0);
        chk("cont_wrote", got_q.size() > 0, 1);
        for (int i = 0; i < got_q.size(); i++) chk("cont_sample", got_q[i], 100);

        // Rejected commands leave RAM untouched.
        send(run_word(3, 0));
        tick(3);
        clear_obs();
        send(wr_word(0, 999));
        send(STOP_WORD);
        wait_idle(10);
        send(32'h7000_0000);
        tick(2);
        chk("err_count", err_cnt, 2);
        clear_obs();
        send(run_word(3, 1));
        wait_idle(20);
        load_exp4();
        check_seq("after_err");

        // Asynchronous reset in the middle of a run.
        send(run_word(3, 0));
        tick(4);
        rst_n = 1'b0;
        #1;
        chk("midrst_wr_en", fifo_wr_en, 0);
        chk("midrst_din", fifo_din, 0);
        chk("midrst_dac", dac_enable, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_state", state_out, 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        clear_obs();
        send(run_word(3, 1));
        wait_idle(20);
        check_seq("after_rst");
        chk("after_rst_done", done_cnt, 1);

`ifdef FGEN_READBACK_EN
        send(wr_word(5, 14'h1ABC));
        rsp_q.delete();
        send({4'h5, 4'h0, 10'd5, 14'h0});
        tick(2);
        chk("rb_count", rsp_q.size(), 1);
        if (rsp_q.size() > 0) begin
            chk("rb_sample", rsp_q[0][13:0], 14'h1ABC);
            chk("rb_addr", rsp_q[0][23:14], 5);
        end
`endif

        // Randomized commands, backpressure and occasional resets.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk); #1;
            fifo_almost_full = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 999) == 0) begin
                rst_n = 1'b0;
                cmd_valid = 1'b0;
            end else begin
                rst_n = 1'b1;
                cmd_valid = ($urandom_range(0, 5) == 0);
                if (cmd_valid) cmd_word = rand_cmd();
            end
        end
        @(negedge clk); #1;
        rst_n = 1'b1;
        cmd_valid = 1'b0;
        fifo_almost_full = 1'b0;
        send(STOP_WORD);
        wait_idle(10);
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, failures so far %0d", n_fail);
        $fatal(1);
    end

endmodule
